// File: rtl/rgb565_dvp_transmit.sv
// rgb565_dvp_transmit
//   OV-camera-style DVP transmitter. RGB565 pixels arrive on a valid/ready stream.
//   They leave as two bytes per pixel, high byte first, on d_o. vsync_o and href_o
//   provide the frame and line timing.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no frame in progress, waiting for enable_i
//   S_VSYNC | vertical sync pulse, vsync_o high for VSYNC_CYC cycles
//   S_VBP   | vertical back porch, V_BP cycles
//   S_LINE  | active line, href_o high for 2*H_ACTIVE cycles
//   S_HBLK  | horizontal blank after every line, H_BLANK cycles
//   S_VFP   | vertical front porch, V_FP cycles, frame_done_o on the last one
//
// Ports
//   pclk_i         in   pixel/byte clock, rising edge
//   rst_i          in   asynchronous reset, active low
//   enable_i       in   emit frames; only looked at on frame boundaries
//   pixel_i        in   RGB565 pixel {R[4:0],G[5:0],B[4:0]}
//   pixel_valid_i  in   pixel_i holds a pixel
//   pixel_ready_o  out  holding register empty
//   d_o            out  DVP data byte
//   vsync_o        out  VSYNC
//   href_o         out  HREF
//   frame_start_o  out  pulse on the first VSYNC cycle of a frame
//   frame_done_o   out  pulse on the last front-porch cycle of a frame
//   underrun_o     out  pulse when an active pixel slot found no pixel
module rgb565_dvp_transmit #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 144,
  parameter int VSYNC_CYC = 1568,
  parameter int V_BP      = 1568,
  parameter int V_FP      = 1568
) (
  input  logic        pclk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [15:0] pixel_i,
  input  logic        pixel_valid_i,
  output logic        pixel_ready_o,
  output logic [7:0]  d_o,
  output logic        vsync_o,
  output logic        href_o,
  output logic        frame_start_o,
  output logic        frame_done_o,
  output logic        underrun_o
);

  localparam int LINE_CYC = 2 * H_ACTIVE;
  localparam int M_A      = (VSYNC_CYC > V_BP) ? VSYNC_CYC : V_BP;
  localparam int M_B      = (V_FP > H_BLANK) ? V_FP : H_BLANK;
  localparam int M_C      = (M_A > M_B) ? M_A : M_B;
  localparam int CNT_MAX  = (M_C > LINE_CYC) ? M_C : LINE_CYC;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int LW       = $clog2(V_ACTIVE + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VSYNC = 3'd1,
    S_VBP   = 3'd2,
    S_LINE  = 3'd3,
    S_HBLK  = 3'd4,
    S_VFP   = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [LW-1:0]   line_cnt, line_nxt;
  logic            phase, phase_nxt;
  logic            full, full_nxt;
  logic [15:0]     hold;
  logic [15:0]     shift, shift_nxt;
  logic [7:0]      d_nxt;
  logic            in_line, slot, consume, underrun, load;

  // Frame sequencing; the down-counter holds the remaining cycles of the current state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    line_nxt  = line_cnt;
    case (state)
      S_IDLE: begin
        if (enable_i) begin
          state_nxt = S_VSYNC;
          cnt_nxt   = CW'(VSYNC_CYC - 1);
        end
      end
      S_VSYNC: begin
        line_nxt = '0;
        if (cnt == '0) begin
          state_nxt = S_VBP;
          cnt_nxt   = CW'(V_BP - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_VBP: begin
        if (cnt == '0) begin
          state_nxt = S_LINE;
          cnt_nxt   = CW'(LINE_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_LINE: begin
        if (cnt == '0) begin
          state_nxt = S_HBLK;
          cnt_nxt   = CW'(H_BLANK - 1);
          line_nxt  = line_cnt + 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_HBLK: begin
        if (cnt == '0) begin
          if (line_cnt < LW'(V_ACTIVE)) begin
            state_nxt = S_LINE;
            cnt_nxt   = CW'(LINE_CYC - 1);
          end else begin
            state_nxt = S_VFP;
            cnt_nxt   = CW'(V_FP - 1);
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_VFP: begin
        if (cnt == '0) begin
          if (enable_i) begin
            state_nxt = S_VSYNC;
            cnt_nxt   = CW'(VSYNC_CYC - 1);
          end else begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pixel path. Outputs are registered from the next-cycle view, so slot decisions
  // use state_nxt/phase_nxt. Load needs an empty register and consume needs a full
  // one, so the two never coincide.
  always_comb begin
    in_line   = (state_nxt == S_LINE);
    phase_nxt = in_line && (state == S_LINE) && !phase;
    slot      = in_line && !phase_nxt;
    consume   = slot && full;
    underrun  = slot && !full;
    load      = pixel_valid_i && pixel_ready_o;
    full_nxt  = load || (full && !consume);
    shift_nxt = shift;
    d_nxt     = 8'h00;
    if (consume) begin
      shift_nxt = hold;
      d_nxt     = hold[15:8];
    end else if (underrun) begin
      shift_nxt = 16'h0000;
    end else if (in_line) begin
      d_nxt = shift[7:0];
    end
  end

  always_ff @(posedge pclk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= S_IDLE;
      cnt           <= '0;
      line_cnt      <= '0;
      phase         <= 1'b0;
      full          <= 1'b0;
      hold          <= 16'h0000;
      shift         <= 16'h0000;
      pixel_ready_o <= 1'b0;
      d_o           <= 8'h00;
      vsync_o       <= 1'b0;
      href_o        <= 1'b0;
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      underrun_o    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      line_cnt      <= line_nxt;
      phase         <= phase_nxt;
      full          <= full_nxt;
      if (load) hold <= pixel_i;
      shift         <= shift_nxt;
      pixel_ready_o <= !full_nxt;
      d_o           <= d_nxt;
      vsync_o       <= (state_nxt == S_VSYNC);
      href_o        <= in_line;
      frame_start_o <= (state_nxt == S_VSYNC) && (state != S_VSYNC);
      frame_done_o  <= (state_nxt == S_VFP) && (cnt_nxt == '0);
      underrun_o    <= underrun;
    end
  end

endmodule
